// File: rtl/alu_if.sv
// Operand/result bundle between the control/datapath side and the ALU.
// The master drives operands and control; the slave returns result and flags.
interface alu_if;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic       SC_in;
  logic [2:0] OP;
  logic       Flag_en;
  logic [7:0] Out;
  logic       Zero;
  logic       SC_out;
  logic       SC_q;
  logic       Zero_q;

  modport master (
    output InputA, InputB, SC_in, OP, Flag_en,
    input  Out, Zero, SC_out, SC_q, Zero_q
  );

  modport slave (
    input  InputA, InputB, SC_in, OP, Flag_en,
    output Out, Zero, SC_out, SC_q, Zero_q
  );
endinterface

// File: rtl/alu.sv
// 8-bit combinational ALU with a clocked status register.
// The status register captures SC_out/Zero when Flag_en is set.
module alu (
  input  logic Clk,
  input  logic Reset_n,
  alu_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_LSH = 3'b001;
  localparam logic [2:0] OP_RSH = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_PAS = 3'b110;
  localparam logic [2:0] OP_RXR = 3'b111;

  function automatic logic f_parity8(input logic [7:0] d);
    return ^d;
  endfunction

  logic [8:0] w_wide;
  logic [7:0] w_out;
  logic       w_sc;
  logic       w_zero;
  logic       r_sc_q;
  logic       r_zero_q;

  // Result and shift/carry select; bit 8 of the 9-bit sum/difference is carry/borrow.
  always_comb begin
    w_wide = 9'd0;
    w_out  = 8'h00;
    w_sc   = 1'b0;
    case (bus.OP)
      OP_ADD: begin
        w_wide = {1'b0, bus.InputA} + {1'b0, bus.InputB};
        w_out  = w_wide[7:0];
        w_sc   = w_wide[8];
      end
      OP_LSH: begin
        w_out = {bus.InputA[6:0], bus.SC_in};
        w_sc  = bus.InputA[7];
      end
      OP_RSH: begin
        w_out = {1'b0, bus.InputA[7:1]};
        w_sc  = bus.InputA[0];
      end
      OP_XOR: w_out = bus.InputA ^ bus.InputB;
      OP_AND: w_out = bus.InputA & bus.InputB;
      OP_SUB: begin
        w_wide = {1'b0, bus.InputA} - {1'b0, bus.InputB};
        w_out  = w_wide[7:0];
        w_sc   = w_wide[8];
      end
      OP_PAS: w_out = bus.InputB;
      OP_RXR: w_out = {7'b0000000, f_parity8(bus.InputA)};
      default: begin
        w_out = 8'h00;
        w_sc  = 1'b0;
      end
    endcase
  end

  assign w_zero = (w_out == 8'h00);

  // Status register: reset wins over capture; otherwise hold.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_sc_q   <= 1'b0;
      r_zero_q <= 1'b0;
    end else if (bus.Flag_en) begin
      r_sc_q   <= w_sc;
      r_zero_q <= w_zero;
    end else begin
      r_sc_q   <= r_sc_q;
      r_zero_q <= r_zero_q;
    end
  end

  assign bus.Out    = w_out;
  assign bus.Zero   = w_zero;
  assign bus.SC_out = w_sc;
  assign bus.SC_q   = r_sc_q;
  assign bus.Zero_q = r_zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: combinational ops and status register timing.
module tb_alu;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  alu_if bus_i ();

  alu dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus_i.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sc, input logic [2:0] op);
    bus_i.InputA = a;
    bus_i.InputB = b;
    bus_i.SC_in  = sc;
    bus_i.OP     = op;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus_i.Flag_en = 1'b0;
    drive(8'h01, 8'h01, 1'b0, 3'b000);
    tick();
    check("reset_sc_q",   {7'd0, bus_i.SC_q},   8'h00);
    check("reset_zero_q", {7'd0, bus_i.Zero_q}, 8'h00);
    check("out_during_reset", bus_i.Out, 8'h02);
    rst_n = 1'b1;

    // ADD
    drive(8'h01, 8'h01, 1'b0, 3'b000);
    check("add_1_1_out",  bus_i.Out, 8'h02);
    check("add_1_1_zero", {7'd0, bus_i.Zero},   8'h00);
    check("add_1_1_sc",   {7'd0, bus_i.SC_out}, 8'h00);
    drive(8'hFF, 8'h01, 1'b1, 3'b000);
    check("add_ff_1_out",  bus_i.Out, 8'h00);
    check("add_ff_1_zero", {7'd0, bus_i.Zero},   8'h01);
    check("add_ff_1_sc",   {7'd0, bus_i.SC_out}, 8'h01);
    bus_i.Flag_en = 1'b1;
    #1;
    check("sc_q_before_edge", {7'd0, bus_i.SC_q}, 8'h00);
    tick();
    bus_i.Flag_en = 1'b0;
    check("cap_sc_q",   {7'd0, bus_i.SC_q},   8'h01);
    check("cap_zero_q", {7'd0, bus_i.Zero_q}, 8'h01);

    // Shifts
    drive(8'h08, 8'h00, 1'b0, 3'b001);
    check("lsh_08_out", bus_i.Out, 8'h10);
    check("lsh_08_sc",  {7'd0, bus_i.SC_out}, 8'h00);
    drive(8'h08, 8'h00, 1'b0, 3'b010);
    check("rsh_08_out", bus_i.Out, 8'h04);
    drive(8'h81, 8'h00, 1'b1, 3'b001);
    check("lsh_81_out", bus_i.Out, 8'h03);
    check("lsh_81_sc",  {7'd0, bus_i.SC_out}, 8'h01);
    drive(8'h81, 8'hFF, 1'b1, 3'b010);
    check("rsh_81_out", bus_i.Out, 8'h40);
    check("rsh_81_sc",  {7'd0, bus_i.SC_out}, 8'h01);

    // Logic
    drive(8'h0F, 8'hF0, 1'b0, 3'b011);
    check("xor_out",  bus_i.Out, 8'hFF);
    check("xor_zero", {7'd0, bus_i.Zero}, 8'h00);
    drive(8'h0F, 8'hF0, 1'b0, 3'b100);
    check("and_out",  bus_i.Out, 8'h00);
    check("and_zero", {7'd0, bus_i.Zero}, 8'h01);
    drive(8'h33, 8'h5A, 1'b1, 3'b110);
    check("pass_out", bus_i.Out, 8'h5A);
    check("pass_sc",  {7'd0, bus_i.SC_out}, 8'h00);

    // SUB and RXR
    drive(8'h04, 8'h01, 1'b0, 3'b101);
    check("sub_4_1_out", bus_i.Out, 8'h03);
    check("sub_4_1_sc",  {7'd0, bus_i.SC_out}, 8'h00);
    drive(8'h01, 8'h02, 1'b0, 3'b101);
    check("sub_1_2_out", bus_i.Out, 8'hFF);
    check("sub_1_2_sc",  {7'd0, bus_i.SC_out}, 8'h01);
    drive(8'h01, 8'hAA, 1'b0, 3'b111);
    check("rxr_01_out", bus_i.Out, 8'h01);
    drive(8'h03, 8'hAA, 1'b0, 3'b111);
    check("rxr_03_out",  bus_i.Out, 8'h00);
    check("rxr_03_zero", {7'd0, bus_i.Zero}, 8'h01);

    // Hold for 3 clocks with Flag_en low and changing inputs
    drive(8'h10, 8'h20, 1'b0, 3'b000);
    tick();
    check("hold1_sc_q", {7'd0, bus_i.SC_q}, 8'h01);
    drive(8'h0F, 8'hF0, 1'b0, 3'b100);
    tick();
    check("hold2_sc_q", {7'd0, bus_i.SC_q}, 8'h01);
    drive(8'h04, 8'h01, 1'b0, 3'b101);
    tick();
    check("hold3_sc_q",   {7'd0, bus_i.SC_q},   8'h01);
    check("hold3_zero_q", {7'd0, bus_i.Zero_q}, 8'h01);
    check("hold3_out",    bus_i.Out, 8'h03);

    // Capture distinct values: AND giving zero with no carry
    drive(8'h0F, 8'hF0, 1'b0, 3'b100);
    bus_i.Flag_en = 1'b1;
    tick();
    check("cap2_sc_q",   {7'd0, bus_i.SC_q},   8'h00);
    check("cap2_zero_q", {7'd0, bus_i.Zero_q}, 8'h01);
    drive(8'h81, 8'h00, 1'b0, 3'b010);
    tick();
    check("cap3_sc_q",   {7'd0, bus_i.SC_q},   8'h01);
    check("cap3_zero_q", {7'd0, bus_i.Zero_q}, 8'h00);

    // Reset together with Flag_en, while SC_out/Zero would set flags
    drive(8'hFF, 8'h01, 1'b0, 3'b000);
    rst_n = 1'b0;
    tick();
    check("rst_sc_q",   {7'd0, bus_i.SC_q},   8'h00);
    check("rst_zero_q", {7'd0, bus_i.Zero_q}, 8'h00);
    check("rst_out",    bus_i.Out, 8'h00);
    check("rst_zero",   {7'd0, bus_i.Zero}, 8'h01);
    rst_n = 1'b1;
    bus_i.Flag_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
